// File: rtl/load_store_unit.sv
// Data-memory access stage: turns core load/store requests into word-addressed
// bus transactions and returns lane-extracted, extended load data.
module load_store_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int CNT_W = $clog2(TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             capture;
   logic             latch_load;

   logic             cap_we;
   logic [2:0]       cap_f3;
   logic [31:0]      cap_addr;
   logic [31:0]      cap_wdata;

   function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~a[0];
         F3_W:    ok = (a == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~a[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_strobe(input logic [2:0] f3,
                                               input logic [1:0] a);
      logic [3:0] s;
      case (f3[1:0])
         2'b00:   s = 4'b0001 << a;
         2'b01:   s = 4'b0011 << {a[1], 1'b0};
         default: s = 4'b1111;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3,
                                               input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [1:0] a,
                                                input logic [31:0] word);
      logic [7:0]         b;
      logic [15:0]        h;
      logic signed [31:0] r;
      b = word[{a, 3'b000} +: 8];
      h = word[{a[1], 4'b0000} +: 16];
      case (f3)
         F3_B:    r = 32'($signed(b));
         F3_H:    r = 32'($signed(h));
         F3_BU:   r = 32'(b);
         F3_HU:   r = 32'(h);
         default: r = word;
      endcase
      return r;
   endfunction

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      capture    = 1'b0;
      latch_load = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               capture   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = access_ok(req_we, funct3, addr[1:0]) ? ISSUE : ERR;
            end
         end
         ISSUE: begin
            // An ack on the final counted cycle still completes the access.
            if (mem_ack) begin
               state_nxt  = RESP;
               latch_load = ~cap_we;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ERR;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RESP:    state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      done      = (state == RESP) || (state == ERR);
      err       = (state == ERR);
      mem_req   = (state == ISSUE);
      mem_we    = 1'b0;
      mem_wstrb = 4'b0000;
      mem_addr  = {cap_addr[31:2], 2'b00};
      mem_wdata = lane_wdata(cap_f3, cap_wdata);
      if (state == ISSUE) begin
         mem_we    = cap_we;
         mem_wstrb = cap_we ? lane_strobe(cap_f3, cap_addr[1:0]) : 4'b0000;
      end
      stall = req_valid & ~done;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (latch_load) rdata <= load_extend(cap_f3, cap_addr[1:0], mem_rdata);
      end
   end

   // Request fields are plain data; they are only meaningful after a capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         cap_we    <= req_we;
         cap_f3    <= funct3;
         cap_addr  <= addr;
         cap_wdata <= wdata;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a driver issues accesses,
// a bus responder answers them, and a monitor checks every done pulse.
module tb_load_store_unit;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        stall, done, err, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .done(done), .err(err), .rdata(rdata), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          start;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          passes = 0;
   int          cyc = 0;

   // Reference bus/transaction model state
   logic        bus_active = 1'b0;
   logic [31:0] b_addr = '0, b_wdata = '0, mem_word = '0;
   logic        b_we = 1'b0;
   logic [3:0]  b_strb = '0;
   int          ack_delay = 0;
   int          wcnt = 0;
   logic [31:0] model_rdata = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
   endtask

   function automatic int size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'd0: return 1;
         2'd1: return 2;
         2'd2: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
      int o = off;
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 0;
      if (we && f3[2]) return 0;
      return (o % size_of(f3)) == 0;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] s = '0;
      int o = off;
      for (int i = 0; i < 4; i++)
         if (i >= o && i < o + size_of(f3)) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (size_of(f3))
         1: return {d[7:0], d[7:0], d[7:0], d[7:0]};
         2: return {d[15:0], d[15:0]};
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] word);
      int          bits = 8 * size_of(f3);
      int          o = off;
      logic [31:0] mask, v;
      mask = (bits >= 32) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 1);
      v = (word >> (8 * o)) & mask;
      if (!f3[2] && bits < 32 && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   always @(posedge clk) cyc = cyc + 1;

   // Bus responder: checks request stability and acks after ack_delay cycles.
   always @(negedge clk) begin
      if (mem_req) begin
         check("bus_req_expected", 32'(mem_req), 32'(bus_active));
         check("mem_addr", mem_addr, b_addr);
         check("mem_we", 32'(mem_we), 32'(b_we));
         check("mem_wstrb", 32'(mem_wstrb), b_we ? 32'(b_strb) : 32'h0);
         if (b_we) check("mem_wdata", mem_wdata, b_wdata);
         mem_ack   = (wcnt == ack_delay);
         mem_rdata = mem_ack ? mem_word : $urandom;
         wcnt++;
      end else begin
         mem_ack = 1'b0;
         wcnt    = 0;
      end
   end

   // Monitor: every done pulse is matched against the scoreboard queue.
   always @(posedge clk) begin
      #1;
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("err", 32'(err), 32'(e.err));
            check("rdata", rdata, e.rdata);
            check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
         end
      end
   end

   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] ad,
                            input logic [31:0] d, input int dly);
      exp_t e;
      bit   ok;
      bit   seen = 0;
      @(negedge clk);
      while (done) @(negedge clk);
      ok         = legal(we, f3, ad[1:0]);
      bus_active = ok;
      b_addr     = {ad[31:2], 2'b00};
      b_we       = we;
      b_strb     = exp_strb(f3, ad[1:0]);
      b_wdata    = exp_wdata(f3, d);
      ack_delay  = dly;
      e.err      = !ok || (dly >= TIMEOUT);
      e.rdata    = (!e.err && !we) ? exp_load(f3, ad[1:0], mem_word) : model_rdata;
      model_rdata = e.rdata;
      e.lat      = !ok ? 1 : ((dly < TIMEOUT) ? 2 + dly : TIMEOUT + 1);
      e.start    = cyc + 1;
      exp_q.push_back(e);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = ad; wdata = d;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk); #1;
         if (done) begin seen = 1; break; end
         check("stall_busy", 32'(stall), 32'h1);
      end
      if (!seen) check("done_within_bound", 32'h0, 32'h1);
      else check("stall_done", 32'(stall), 32'h0);
      req_valid = 1'b0;
      bus_active = 1'b0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      check("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_stall", 32'(stall), 32'h0);
      @(negedge clk) rst = 1'b0;

      mem_word = 32'hDEAD_BEEF;
      do_access(1'b0, 3'b010, 32'h100, 32'h0, 0);
      mem_word = 32'h80FF_0000;
      do_access(1'b0, 3'b000, 32'h103, 32'h0, 0);
      do_access(1'b0, 3'b100, 32'h103, 32'h0, 1);
      do_access(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 0);
      do_access(1'b0, 3'b010, 32'h102, 32'h0, 0);
      mem_word = 32'h1357_9BDF;
      do_access(1'b0, 3'b101, 32'h206, 32'h0, 5);
      do_access(1'b0, 3'b010, 32'h300, 32'h0, 100);
      do_access(1'b0, 3'b001, 32'h302, 32'h0, TIMEOUT - 1);
      do_access(1'b1, 3'b100, 32'h40, 32'h55, 0);
      do_access(1'b0, 3'b011, 32'h40, 32'h0, 0);
      do_access(1'b1, 3'b000, 32'h41, 32'hA5, 2);

      // Reset while the bus request is outstanding: no done may follow.
      @(negedge clk);
      bus_active = 1'b1; b_addr = 32'h40; b_we = 1'b0; ack_delay = 1000;
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h40;
      repeat (3) @(posedge clk);
      @(negedge clk) begin rst = 1'b1; req_valid = 1'b0; end
      @(posedge clk); #1;
      check("midrst_mem_req", 32'(mem_req), 32'h0);
      check("midrst_done", 32'(done), 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      model_rdata = '0;
      bus_active = 1'b0;
      @(negedge clk) rst = 1'b0;
      repeat (3) @(posedge clk);
      mem_word = 32'hCAFE_F00D;
      do_access(1'b0, 3'b010, 32'h80, 32'h0, 0);

      for (int k = 0; k < 60; k++) begin
         logic [31:0] ad;
         int          r, dly;
         ad = $urandom;
         if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
         r = $urandom_range(0, 9);
         dly = (r < 8) ? $urandom_range(0, 4) : ((r == 8) ? TIMEOUT - 1 : TIMEOUT + $urandom_range(0, 4));
         mem_word = $urandom;
         do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ad, $urandom, dly);
      end

      repeat (4) @(posedge clk);
      #2;
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
